io_access_arbiter: RTL and testbench

//  Shares the board IO block (switch/button status, 7-seg value register) between NREQ
//  bus masters (CPU data port, debug/serial loader, ...). Each master issues single

---
 rtl/io_map_pkg.sv | 18 +
 rtl/rr_pick.sv | 34 +++
 rtl/io_access_arbiter.sv | 160 ++++++++++++++++
 tb/tb_io_access_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// Shared IO address map, FSM state encoding and widths for the IO access arbiter.
package io_map_pkg;

  localparam int IO_ADDR_SWITCH = 0;
  localparam int IO_ADDR_BUTTON = 1;
  localparam int IO_ADDR_SSD    = 2;

  // grant_id / last_grant width, enough for up to 8 masters
  localparam int GRANT_W = 3;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } io_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at an index above last_grant, wrapping.
module rr_pick
  import io_map_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]    req,
  input  logic [GRANT_W-1:0] last_grant,
  output logic [GRANT_W-1:0] idx,
  output logic               valid
);

  localparam int SW = GRANT_W + 1;

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [GRANT_W-1:0] off;
  logic [SW-1:0]     sum;

  always_comb begin
    // rotate so that bit 0 is the master just after last_grant
    dbl = {req, req} >> ({1'b0, last_grant} + SW'(1));
    rot = dbl[NREQ-1:0];
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) off = GRANT_W'(k);
    end
    sum = {1'b0, last_grant} + {1'b0, off} + SW'(1);
    if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
    idx   = sum[GRANT_W-1:0];
    valid = |req;
  end

endmodule

// File: rtl/io_access_arbiter.sv
// Round-robin arbiter sharing the board IO block between NREQ req/ack bus masters.
module io_access_arbiter
  import io_map_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        we,
  input  logic [NREQ*ADDR_W-1:0] addr,
  input  logic [NREQ*32-1:0]     wdata,
  output logic [NREQ-1:0]        ack,
  output logic [31:0]            rdata,
  output logic                   err,
  output logic [GRANT_W-1:0]     grant_id,
  output logic                   busy,
  input  logic [7:0]             io_switch_status,
  input  logic [3:0]             io_button_status,
  input  logic [31:0]            io_ssd_value,
  output logic [31:0]            ssd_write_value,
  output logic                   ssd_write_enable
);

  io_state_e state_reg, state_next;

  logic [ADDR_W-1:0] addr_arr  [MAX_REQ];
  logic [31:0]       wdata_arr [MAX_REQ];
  logic [MAX_REQ-1:0] we_arr;
  logic [NREQ-1:0]   grant_onehot;

  logic [GRANT_W-1:0] pick_idx;
  logic               pick_valid;

  logic [GRANT_W-1:0] grant_id_reg, grant_id_next;
  logic [GRANT_W-1:0] last_grant_reg, last_grant_next;
  logic               we_reg, we_next;
  logic [ADDR_W-1:0]  addr_reg, addr_next;
  logic [NREQ-1:0]    ack_reg, ack_next;
  logic [31:0]        rdata_reg, rdata_next;
  logic               err_reg, err_next;
  logic               ssd_we_reg, ssd_we_next;
  logic [31:0]        ssd_val_reg, ssd_val_next;

  // unpack per-master fields; unused slots are tied off so an index never runs off the end
  generate
    for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_lane
      if (gi < NREQ) begin : g_used
        assign addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = wdata[gi*32 +: 32];
        assign we_arr[gi]    = we[gi];
      end else begin : g_tie
        assign addr_arr[gi]  = '0;
        assign wdata_arr[gi] = '0;
        assign we_arr[gi]    = 1'b0;
      end
    end
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ack
      assign grant_onehot[gi] = (grant_id_reg == GRANT_W'(gi));
    end
  endgenerate

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req        (req),
    .last_grant (last_grant_reg),
    .idx        (pick_idx),
    .valid      (pick_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: if (pick_valid) state_next = ST_XFER;
      ST_XFER: state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_id_next   = grant_id_reg;
    last_grant_next = last_grant_reg;
    we_next         = we_reg;
    addr_next       = addr_reg;
    ack_next        = '0;
    rdata_next      = rdata_reg;
    err_next        = err_reg;
    ssd_we_next     = 1'b0;
    ssd_val_next    = ssd_val_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_id_next = pick_idx;
          we_next       = we_arr[pick_idx];
          addr_next     = addr_arr[pick_idx];
          // registered here so the SSD write strobe lands exactly in the XFER cycle
          if (we_arr[pick_idx] && addr_arr[pick_idx] == ADDR_W'(IO_ADDR_SSD)) begin
            ssd_we_next  = 1'b1;
            ssd_val_next = wdata_arr[pick_idx];
          end
        end
      end
      ST_XFER: begin
        ack_next   = grant_onehot;
        rdata_next = '0;
        err_next   = 1'b0;
        if (addr_reg == ADDR_W'(IO_ADDR_SSD)) begin
          if (!we_reg) rdata_next = io_ssd_value;
        end else if (!we_reg && addr_reg == ADDR_W'(IO_ADDR_SWITCH)) begin
          rdata_next = {24'h0, io_switch_status};
        end else if (!we_reg && addr_reg == ADDR_W'(IO_ADDR_BUTTON)) begin
          rdata_next = {28'h0, io_button_status};
        end else begin
          err_next = 1'b1;
        end
      end
      ST_RESP: last_grant_next = grant_id_reg;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id_reg   <= '0;
      last_grant_reg <= GRANT_W'(NREQ - 1);
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      ack_reg        <= '0;
      rdata_reg      <= '0;
      err_reg        <= 1'b0;
      ssd_we_reg     <= 1'b0;
      ssd_val_reg    <= '0;
    end else begin
      grant_id_reg   <= grant_id_next;
      last_grant_reg <= last_grant_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
      ack_reg        <= ack_next;
      rdata_reg      <= rdata_next;
      err_reg        <= err_next;
      ssd_we_reg     <= ssd_we_next;
      ssd_val_reg    <= ssd_val_next;
    end
  end

  assign ack              = ack_reg;
  assign rdata            = rdata_reg;
  assign err              = err_reg;
  assign grant_id         = grant_id_reg;
  assign busy             = (state_reg != ST_IDLE);
  assign ssd_write_enable = ssd_we_reg;
  assign ssd_write_value  = ssd_val_reg;

endmodule

// File: tb/tb_io_access_arbiter.sv
// Directed bench for io_access_arbiter with two masters and a small IO block model.
module tb_io_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we;
  logic [7:0]  addr;
  logic [63:0] wdata;
  logic [1:0]  ack;
  logic [31:0] rdata;
  logic        err;
  logic [2:0]  grant_id;
  logic        busy;
  logic [7:0]  sw;
  logic [3:0]  btn;
  logic [31:0] ssd_model = '0;
  logic [31:0] ssd_val;
  logic        ssd_we;

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr    = 0;
  int n_both  = 0;

  io_access_arbiter #(.NREQ(2), .ADDR_W(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .we               (we),
    .addr             (addr),
    .wdata            (wdata),
    .ack              (ack),
    .rdata            (rdata),
    .err              (err),
    .grant_id         (grant_id),
    .busy             (busy),
    .io_switch_status (sw),
    .io_button_status (btn),
    .io_ssd_value     (ssd_model),
    .ssd_write_value  (ssd_val),
    .ssd_write_enable (ssd_we)
  );

  always #5 clk = ~clk;

  // IO block model: SSD register plus write/ack-overlap counters
  always @(posedge clk) begin
    if (!rst) begin
      if (ssd_we) begin
        ssd_model <= ssd_val;
        n_wr      <= n_wr + 1;
      end
      if (ack == 2'b11) n_both <= n_both + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] t_rdata;
  logic        t_err;
  int          t_lat;
  logic [1:0]  t_ack;
  logic        t_xwe;
  logic [31:0] t_xval;
  logic [2:0]  t_gid;

  task automatic wait_ack();
    t_lat = 0;
    t_ack = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      t_lat++;
      if (t_lat == 1) begin
        t_xwe  = ssd_we;
        t_xval = ssd_val;
        t_gid  = grant_id;
      end
      if (ack != 2'b00) begin
        t_ack = ack;
        break;
      end
    end
    t_rdata = rdata;
    t_err   = err;
  endtask

  // one transaction from an idle arbiter; returns one cycle into the following IDLE
  task automatic txn(input int m, input logic w, input logic [3:0] a, input logic [31:0] d);
    we[m]             = w;
    addr[m*4 +: 4]    = a;
    wdata[m*32 +: 32] = d;
    req[m]            = 1'b1;
    wait_ack();
    req[m] = 1'b0;
    step();
  endtask

  logic [1:0]  ack_seq [8];
  int          cyc_seq [8];
  logic [31:0] rd_seq  [8];
  logic [1:0]  exp_ack [4];
  logic [31:0] exp_rd  [4];
  int          nseq;
  int          wr_before;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    sw = 8'hA5; btn = 4'h9;
    t_xwe = 1'b0; t_xval = '0; t_gid = '0;
    repeat (2) step();
    check("rst_ack",      32'(ack), 32'h0);
    check("rst_rdata",    rdata, 32'h0);
    check("rst_err",      32'(err), 32'h0);
    check("rst_busy",     32'(busy), 32'h0);
    check("rst_grant",    32'(grant_id), 32'h0);
    check("rst_ssd_we",   32'(ssd_we), 32'h0);
    check("rst_ssd_val",  ssd_val, 32'h0);
    rst = 1'b0;
    step();

    // T1: m0 reads switches
    txn(0, 1'b0, 4'h0, 32'h0);
    check("t1_lat",        32'(t_lat), 32'd2);
    check("t1_ack",        32'(t_ack), 32'h1);
    check("t1_rdata",      t_rdata, 32'h0000_00A5);
    check("t1_err",        32'(t_err), 32'h0);
    check("t1_rdata_hold", rdata, 32'h0000_00A5);
    check("t1_ack_idle",   32'(ack), 32'h0);

    // T2: m1 writes SSD then reads it back
    txn(1, 1'b1, 4'h2, 32'hDEAD_BEEF);
    check("t2w_ack",      32'(t_ack), 32'h2);
    check("t2w_grant",    32'(t_gid), 32'h1);
    check("t2w_xfer_we",  32'(t_xwe), 32'h1);
    check("t2w_xfer_val", t_xval, 32'hDEAD_BEEF);
    check("t2w_err",      32'(t_err), 32'h0);
    check("t2w_nwr",      32'(n_wr), 32'd1);
    check("t2w_ssd",      ssd_model, 32'hDEAD_BEEF);
    txn(1, 1'b0, 4'h2, 32'h0);
    check("t2r_ack",      32'(t_ack), 32'h2);
    check("t2r_rdata",    t_rdata, 32'hDEAD_BEEF);
    check("t2r_xfer_we",  32'(t_xwe), 32'h0);

    // T3: both masters hold req; m0 reads switches, m1 reads buttons
    we = 2'b00; addr = 8'h10;
    exp_ack = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_rd  = '{32'hA5, 32'h9, 32'hA5, 32'h9};
    for (int j = 0; j < 8; j++) begin
      ack_seq[j] = '0; cyc_seq[j] = 0; rd_seq[j] = '0;
    end
    nseq = 0;
    req = 2'b11;
    for (int c = 1; c <= 11; c++) begin
      step();
      if (ack != 2'b00 && nseq < 8) begin
        ack_seq[nseq] = ack; cyc_seq[nseq] = c; rd_seq[nseq] = rdata;
        nseq++;
      end
    end
    req = 2'b00;
    step();
    check("t3_count", 32'(nseq), 32'd4);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("t3_ack%0d", j),   32'(ack_seq[j]), 32'(exp_ack[j]));
      check($sformatf("t3_cyc%0d", j),   32'(cyc_seq[j]), 32'(3 * j + 2));
      check($sformatf("t3_rdata%0d", j), rd_seq[j], exp_rd[j]);
    end
    check("t3_both_ack", 32'(n_both), 32'd0);

    // T4: bad accesses
    wr_before = n_wr;
    txn(0, 1'b1, 4'h1, 32'h5555_5555);
    check("t4w_ack",      32'(t_ack), 32'h1);
    check("t4w_err",      32'(t_err), 32'h1);
    check("t4w_rdata",    t_rdata, 32'h0);
    check("t4w_xfer_we",  32'(t_xwe), 32'h0);
    check("t4w_err_hold", 32'(err), 32'h1);
    txn(0, 1'b0, 4'h7, 32'h0);
    check("t4r_err",      32'(t_err), 32'h1);
    check("t4r_rdata",    t_rdata, 32'h0);
    check("t4_nwr",       32'(n_wr), 32'(wr_before));
    check("t4_ssd",       ssd_model, 32'hDEAD_BEEF);
    txn(0, 1'b0, 4'h0, 32'h0);
    check("t4ok_err",     32'(t_err), 32'h0);
    check("t4ok_rdata",   t_rdata, 32'hA5);

    // T5: reset during the XFER cycle of an SSD write
    we[0] = 1'b1; addr[3:0] = 4'h2; wdata[31:0] = 32'h1234_5678; req[0] = 1'b1;
    step();
    check("t5_xfer_we",   32'(ssd_we), 32'h1);
    check("t5_xfer_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    check("t5_rst_we",    32'(ssd_we), 32'h0);
    check("t5_rst_busy",  32'(busy), 32'h0);
    check("t5_rst_grant", 32'(grant_id), 32'h0);
    repeat (2) step();
    check("t5_rst_ack",   32'(ack), 32'h0);
    req[0] = 1'b0;
    rst = 1'b0;
    step();
    check("t5_nwr",       32'(n_wr), 32'(wr_before));
    check("t5_ssd",       ssd_model, 32'hDEAD_BEEF);
    we = 2'b00; addr = 8'h10; req = 2'b11;
    wait_ack();
    check("t5_first_ack", 32'(t_ack), 32'h1);
    check("t5_first_rd",  t_rdata, 32'hA5);
    req[0] = 1'b0;
    step();
    wait_ack();
    check("t5_second_ack", 32'(t_ack), 32'h2);
    check("t5_second_rd",  t_rdata, 32'h9);
    req = 2'b00;
    step();

    // T6: m0 drops req right after grant; m1 waiting with an SSD write
    we = 2'b10; addr = 8'h20; wdata = {32'hCAFE_F00D, 32'h0};
    req[0] = 1'b1;
    step();
    check("t6_grant0",   32'(grant_id), 32'h0);
    check("t6_busy_x",   32'(busy), 32'h1);
    req[0] = 1'b0; req[1] = 1'b1;
    step();
    check("t6_ack0",     32'(ack), 32'h1);
    check("t6_rdata0",   rdata, 32'hA5);
    step();
    check("t6_idle_ack", 32'(ack), 32'h0);
    check("t6_idle_busy", 32'(busy), 32'h0);
    step();
    check("t6_grant1",   32'(grant_id), 32'h1);
    check("t6_ssd_we",   32'(ssd_we), 32'h1);
    check("t6_ssd_val",  ssd_val, 32'hCAFE_F00D);
    step();
    check("t6_ack1",     32'(ack), 32'h2);
    req[1] = 1'b0;
    step();
    check("t6_ssd",      ssd_model, 32'hCAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
